// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - request/response and RAM-port bundle for mem_ctrl
//
// Groups the byte-wide RAM port, the LSB load/store channel and the
// instruction-fetch channel.
//   slave  : mem_ctrl side (takes requests and RAM read data, drives RAM and responses)
//   master : requester/RAM side (drives requests and RAM read data)
interface mem_ctrl_if;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        lsb_req;
   logic        lsb_we;
   logic [1:0]  lsb_width;
   logic        lsb_sext;
   logic [31:0] lsb_addr;
   logic [31:0] lsb_wdata;
   logic        lsb_done;
   logic [31:0] lsb_rdata;
   logic        if_req;
   logic [31:0] if_pc;
   logic        if_done;
   logic [31:0] if_inst;
   logic [31:0] if_inst_addr;

   modport slave (
      input  mem_din, lsb_req, lsb_we, lsb_width, lsb_sext, lsb_addr, lsb_wdata,
             if_req, if_pc,
      output mem_dout, mem_a, mem_wr, lsb_done, lsb_rdata, if_done, if_inst, if_inst_addr
   );

   modport master (
      output mem_din, lsb_req, lsb_we, lsb_width, lsb_sext, lsb_addr, lsb_wdata,
             if_req, if_pc,
      input  mem_dout, mem_a, mem_wr, lsb_done, lsb_rdata, if_done, if_inst, if_inst_addr
   );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - fetch/LSB arbiter onto an 8-bit RAM port with a direct-mapped I-cache
//
// Ports:
//   clk_in        rising-edge clock
//   rst_in        asynchronous active-low reset
//   rdy_in        global ready; low pauses everything
//   rob_clear_up  pipeline flush; aborts reads, never stores
//   bus           mem_ctrl_if.slave: RAM port, LSB channel, fetch channel
module mem_ctrl #(
   parameter int ICACHE_IDX_W = 6,
   parameter bit ICACHE_EN    = 1'b1
) (
   input  logic      clk_in,
   input  logic      rst_in,
   input  logic      rdy_in,
   input  logic      rob_clear_up,
   mem_ctrl_if.slave bus
);
   localparam int DEPTH = 1 << ICACHE_IDX_W;
   localparam int TAG_W = 30 - ICACHE_IDX_W;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

   state_t      state_q, state_d;
   logic        is_fetch_q, is_fetch_d;
   logic [31:0] base_q, base_d;
   logic [2:0]  n_q, n_d;
   logic [2:0]  cap_q, cap_d;
   logic        pend_q, pend_d;
   logic [2:0]  idx_q, idx_d;
   logic [31:0] buf_q, buf_d;       // load assembly in READ, store data in WRITE
   logic [1:0]  width_q, width_d;
   logic        sext_q, sext_d;
   logic        lsb_done_q, lsb_done_d;
   logic        st_done_q, st_done_d; // lsb_done belongs to a store (survives flush)
   logic [31:0] lsb_rdata_q, lsb_rdata_d;
   logic        if_done_q, if_done_d;
   logic [31:0] if_inst_q, if_inst_d;
   logic [31:0] if_inst_addr_q, if_inst_addr_d;
   logic [DEPTH-1:0] valid_q, valid_d;

   logic [TAG_W-1:0] tag_mem  [DEPTH];
   logic [31:0]      line_mem [DEPTH];
   logic                    fill_en;
   logic [ICACHE_IDX_W-1:0] fill_idx;
   logic [TAG_W-1:0]        fill_tag;
   logic [31:0]             fill_data;

   logic [7:0]  mem_dout_o;
   logic [31:0] mem_a_o;
   logic        mem_wr_o;

   logic [ICACHE_IDX_W-1:0] pc_idx, st_idx;
   logic [TAG_W-1:0]        pc_tag, st_tag;
   logic                    fetch_hit, st_hit, can_accept;

   assign pc_idx = bus.if_pc[ICACHE_IDX_W+1:2];
   assign pc_tag = bus.if_pc[31:ICACHE_IDX_W+2];
   assign st_idx = bus.lsb_addr[ICACHE_IDX_W+1:2];
   assign st_tag = bus.lsb_addr[31:ICACHE_IDX_W+2];

   assign fetch_hit  = ICACHE_EN && valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
   assign st_hit     = valid_q[st_idx] && (tag_mem[st_idx] == st_tag);
   // A done pulse still on the bus blocks acceptance so the requester can drop req.
   assign can_accept = rdy_in && !rob_clear_up && !lsb_done_q && !if_done_q;

   function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] w,
                                          input logic s);
      case (w)
         2'd0:    extend = {{24{s & d[7]}}, d[7:0]};
         2'd1:    extend = {{16{s & d[15]}}, d[15:0]};
         default: extend = d;
      endcase
   endfunction

   // State register
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Datapath and response registers
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         is_fetch_q     <= 1'b0;
         base_q         <= '0;
         n_q            <= '0;
         cap_q          <= '0;
         pend_q         <= 1'b0;
         idx_q          <= '0;
         buf_q          <= '0;
         width_q        <= '0;
         sext_q         <= 1'b0;
         lsb_done_q     <= 1'b0;
         st_done_q      <= 1'b0;
         lsb_rdata_q    <= '0;
         if_done_q      <= 1'b0;
         if_inst_q      <= '0;
         if_inst_addr_q <= '0;
         valid_q        <= '0;
      end else begin
         is_fetch_q     <= is_fetch_d;
         base_q         <= base_d;
         n_q            <= n_d;
         cap_q          <= cap_d;
         pend_q         <= pend_d;
         idx_q          <= idx_d;
         buf_q          <= buf_d;
         width_q        <= width_d;
         sext_q         <= sext_d;
         lsb_done_q     <= lsb_done_d;
         st_done_q      <= st_done_d;
         lsb_rdata_q    <= lsb_rdata_d;
         if_done_q      <= if_done_d;
         if_inst_q      <= if_inst_d;
         if_inst_addr_q <= if_inst_addr_d;
         valid_q        <= valid_d;
      end
   end

   // Cache tag/data arrays need no reset: valid_q guards every read.
   always_ff @(posedge clk_in) begin
      if (fill_en) begin
         tag_mem[fill_idx]  <= fill_tag;
         line_mem[fill_idx] <= fill_data;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d        = state_q;
      is_fetch_d     = is_fetch_q;
      base_d         = base_q;
      n_d            = n_q;
      cap_d          = cap_q;
      pend_d         = pend_q;
      idx_d          = idx_q;
      buf_d          = buf_q;
      width_d        = width_q;
      sext_d         = sext_q;
      lsb_done_d     = lsb_done_q;
      st_done_d      = st_done_q;
      lsb_rdata_d    = lsb_rdata_q;
      if_done_d      = if_done_q;
      if_inst_d      = if_inst_q;
      if_inst_addr_d = if_inst_addr_q;
      valid_d        = valid_q;
      fill_en        = 1'b0;
      fill_idx       = base_q[ICACHE_IDX_W+1:2];
      fill_tag       = base_q[31:ICACHE_IDX_W+2];
      fill_data      = buf_q;

      // Done pulses live until a ready edge; a flush kills a pending load/fetch
      // result but not a store completion.
      if (rdy_in) begin
         lsb_done_d     = 1'b0;
         st_done_d      = 1'b0;
         lsb_rdata_d    = '0;
         if_done_d      = 1'b0;
         if_inst_d      = '0;
         if_inst_addr_d = '0;
      end else if (rob_clear_up) begin
         if_done_d      = 1'b0;
         if_inst_d      = '0;
         if_inst_addr_d = '0;
         if (!st_done_q) begin
            lsb_done_d  = 1'b0;
            lsb_rdata_d = '0;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (can_accept) begin
               if (bus.lsb_req) begin
                  is_fetch_d = 1'b0;
                  base_d     = bus.lsb_addr;
                  n_d        = 3'd1 << bus.lsb_width;
                  width_d    = bus.lsb_width;
                  sext_d     = bus.lsb_sext;
                  cap_d      = '0;
                  pend_d     = 1'b0;
                  idx_d      = '0;
                  if (bus.lsb_we) begin
                     state_d = S_WRITE;
                     buf_d   = bus.lsb_wdata;
                     if (st_hit) valid_d[st_idx] = 1'b0;
                  end else begin
                     state_d = S_READ;
                     buf_d   = '0;
                  end
               end else if (bus.if_req) begin
                  if (fetch_hit) begin
                     if_done_d      = 1'b1;
                     if_inst_d      = line_mem[pc_idx];
                     if_inst_addr_d = bus.if_pc;
                  end else begin
                     state_d    = S_READ;
                     is_fetch_d = 1'b1;
                     base_d     = bus.if_pc;
                     n_d        = 3'd4;
                     width_d    = 2'd2;
                     sext_d     = 1'b0;
                     cap_d      = '0;
                     pend_d     = 1'b0;
                     buf_d      = '0;
                  end
               end
            end
         end

         S_READ: begin
            if (rob_clear_up) begin
               state_d = S_IDLE;
               pend_d  = 1'b0;
               cap_d   = '0;
            end else if (rdy_in) begin
               // mem_din answers the address issued last cycle, which is byte cap.
               if (pend_q) begin
                  buf_d[{cap_q[1:0], 3'b000} +: 8] = bus.mem_din;
                  cap_d = cap_q + 3'd1;
               end
               if (cap_d == n_q) begin
                  state_d = S_IDLE;
                  pend_d  = 1'b0;
                  if (is_fetch_q) begin
                     if_done_d      = 1'b1;
                     if_inst_d      = buf_d;
                     if_inst_addr_d = base_q;
                     if (ICACHE_EN) begin
                        fill_en           = 1'b1;
                        fill_data         = buf_d;
                        valid_d[fill_idx] = 1'b1;
                     end
                  end else begin
                     lsb_done_d  = 1'b1;
                     st_done_d   = 1'b0;
                     lsb_rdata_d = extend(buf_d, width_q, sext_q);
                  end
               end else begin
                  pend_d = 1'b1;
               end
            end else begin
               // Stall: whatever was in flight is lost, re-issue after the stall.
               pend_d = 1'b0;
            end
         end

         S_WRITE: begin
            if (rdy_in) begin
               idx_d = idx_q + 3'd1;
               if (idx_q == n_q - 3'd1) begin
                  state_d     = S_IDLE;
                  lsb_done_d  = 1'b1;
                  st_done_d   = 1'b1;
                  lsb_rdata_d = '0;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // RAM port outputs
   always_comb begin
      mem_a_o    = '0;
      mem_wr_o   = 1'b0;
      mem_dout_o = '0;
      case (state_q)
         S_READ: mem_a_o = base_q + {29'd0, cap_q} + {31'd0, pend_q};
         S_WRITE: begin
            mem_a_o = base_q + {29'd0, idx_q};
            if (rdy_in) begin
               mem_wr_o   = 1'b1;
               mem_dout_o = buf_q[{idx_q[1:0], 3'b000} +: 8];
            end
         end
         default: ;
      endcase
   end

   assign bus.mem_a        = mem_a_o;
   assign bus.mem_wr       = mem_wr_o;
   assign bus.mem_dout     = mem_dout_o;
   assign bus.lsb_done     = lsb_done_q;
   assign bus.lsb_rdata    = lsb_rdata_q;
   assign bus.if_done      = if_done_q;
   assign bus.if_inst      = if_inst_q;
   assign bus.if_inst_addr = if_inst_addr_q;
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Parametrised successor to the single-request byte-serial cache front end: arbitrates instruction fetch and LSB load/store onto the 8-bit RAM port, and adds a direct-mapped instruction cache. Cache hits return in one cycle. The block adds clean `rdy_in` stall recovery and explicit done/ack handshakes, and sits between the instruction fetcher/LSB and the RAM/IO bus.

## Interface
- ICACHE_IDX_W, 6: index bits; the cache holds 2^ICACHE_IDX_W one-word lines.
- ICACHE_EN, 1: 1 = cache in use; 0 = every fetch is a miss and nothing is filled.
- clk_in  input  1  system clock, rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  global ready; low = pause.
- rob_clear_up  input  1  pipeline flush.
- mem_din  input  8  RAM read byte for the address presented in the previous cycle.
- mem_dout  output  8  RAM write byte.
- mem_a  output  32  RAM byte address.
- mem_wr  output  1  1 = write.
- lsb_req  input  1  LSB request, level; held until lsb_done.
- lsb_we  input  1  1 = store.
- lsb_width  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- lsb_sext  input  1  sign-extend the load result.
- lsb_addr  input  32  byte address; any alignment allowed.
- lsb_wdata  input  32  store data; the low bytes are used.
- lsb_done  output  1  one-cycle completion pulse.
- lsb_rdata  output  32  load result; valid with lsb_done, otherwise 0.
- if_req  input  1  fetch request, level; held until if_done.
- if_pc  input  32  fetch address; bits [1:0] must be 0.
- if_done  output  1  one-cycle completion pulse.
- if_inst  output  32  instruction; valid with if_done, otherwise 0.
- if_inst_addr  output  32  address of the returned instruction; valid with if_done, otherwise 0.

## Operation
- States: IDLE, READ (load or fetch miss), WRITE. Byte order is little-endian: byte k is at base+k. n = 1 << lsb_width; fetch n = 4.
- **Acceptance (IDLE):**
  - A request is accepted only when rdy_in=1, rob_clear_up=0, and neither done output is high this cycle.
  - LSB has priority over fetch.
  - Requesters must drop req in their done cycle.
- **Fetch:**
  - index = if_pc[ICACHE_IDX_W+1:2]; tag = if_pc[31:ICACHE_IDX_W+2].
  - Hit (valid and tag match): stay in IDLE; if_done plus data are registered next cycle.
  - Miss: go to READ.
- **READ:**
  - Registers: cap = bytes captured, pend = an address was issued last cycle with rdy_in high.
  - mem_a = base + cap + pend; mem_wr = 0.
  - In each rdy_in-high cycle: if pend, capture mem_din into byte cap and increment cap. Then pend <= (cap_next < n).
  - When cap reaches n, go to IDLE and register the done pulse and result.
  - A fetch miss also writes the line and sets valid.
- **Load result:**
  - Zero-extend, or sign-extend from bit 8n-1 when lsb_sext=1.
  - lsb_sext with word width is ignored.
- **WRITE:**
  - Byte counter idx. In each rdy_in-high cycle: mem_wr=1, mem_a = base+idx, mem_dout = lsb_wdata byte idx; idx++.
  - After byte n-1, go to IDLE and pulse lsb_done.
  - At acceptance, a cache line whose valid bit and tag match the store's word address is invalidated.
- **IDLE outputs:** mem_a=0, mem_wr=0, mem_dout=0.
- **rdy_in low:**
  - All state holds; mem_wr forced 0; pend cleared, so the next ready cycle re-issues the uncaptured byte.
  - Done pulses stay high until a rdy_in-high edge consumes them.
- **rob_clear_up:**
  - READ is aborted to IDLE with no done pulse and no cache fill. A pending (not yet consumed) done pulse is cleared.
  - WRITE is never aborted: a committed store completes and its lsb_done still pulses.
  - Cache contents survive the flush.
- **Reset:** all outputs 0, state IDLE, all valid bits cleared. Reset asserting mid-transaction abandons it immediately.

## Timing
- Load or fetch miss, no stall: accept edge E, then n+1 READ cycles; done is high in cycle E+n+2. Word load: done 6 cycles after the accept cycle; byte load: 3.
- Fetch hit: if_done in the cycle after the accept cycle.
- Store: mem_wr is high for n consecutive cycles starting the cycle after accept; lsb_done in the cycle after the last byte.
- Each stall cycle adds one cycle; one extra re-issue cycle follows each stall inside READ.
- Back-to-back: a new request can be accepted in the cycle after a done pulse.

## Test plan
- Reset, then fetch pc=0x100 (RAM 0x100..0x103 = 13 05 10 00): miss, mem_a sequence 0x100..0x103, if_inst=0x00100513 at cycle 6. Re-fetch 0x100: if_done next cycle, no mem_a activity.
- lsb_req store word 0xDEADBEEF @0x100 with the line cached: mem_wr bytes EF BE AD DE at 0x100..0x103, line invalidated. Next fetch of 0x100 misses and returns 0xDEADBEEF.
- Simultaneous if_req and lsb load byte @0x20 (0x80), lsb_sext=1: LSB served first, lsb_rdata=0xFFFFFF80. Fetch served afterwards. Repeat with lsb_sext=0: 0x00000080.
- Half load @0x41 with rdy_in low for 3 cycles after the first capture: mem_wr stays 0, the byte is re-issued, result is correct, latency +4.
- rob_clear_up during a fetch miss: no if_done, line stays invalid. rob_clear_up during a word store: all 4 writes complete and lsb_done pulses.
- ICACHE_EN=0: two fetches of the same pc both take the full miss latency.
